pwm_frame_ctrl: RTL and testbench
=================================

Name: pwm_frame_ctrl

Overview:
Double-buffered frame store and update sequencer for the binary-coded-modulation PWM datapath. A host writes per-channel duty values into a shadow bank and requests a commit. The block swaps banks only on the PWM frame boundary (latch_mem), then copies the new active bank back into the shadow bank so later partial updates stay coherent. It serves the bit-plane read port (pwm_addr -> pwm_data) of the PWM block.

Parameters:
pwm_width, 16, bits per channel duty value (number of bit planes)
num_pwm, 4, number of PWM channels

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
wr_valid  in  1  host write request
wr_ready  out  1  write accepted when wr_valid & wr_ready at posedge
wr_chan  in  max(1,$clog2(num_pwm))  target channel
wr_value  in  pwm_width  duty value
commit  in  1  single-cycle pulse: publish shadow bank at next frame boundary
busy  out  1  commit pending or copy in progress
commit_done  out  1  one-cycle pulse when commit sequence completes
pwm_addr  in  $clog2(pwm_width)  bit-plane index from PWM block
latch_mem  in  1  frame-boundary strobe from PWM block
pwm_data  out  num_pwm  bit pwm_addr of each channel in the displayed bank

Behaviour:
- Storage: two banks, bank[2][num_pwm] of pwm_width bits each. The active_bank flag selects the displayed bank; the other bank is the shadow.
- Reset (rst_n low, async): all bank entries 0; active_bank=0; state IDLE; copy counter 0. Outputs: wr_ready=1, busy=0, commit_done=0, pwm_data=0.
- FSM states: IDLE, PENDING, COPY.
- IDLE:
  - wr_ready=1; an accepted write stores wr_value into shadow[wr_chan] at the clock edge.
  - commit=1 moves to PENDING. A write accepted in the same cycle as commit is included in the commit.
  - latch_mem in IDLE has no effect.
- PENDING:
  - wr_ready=0, busy=1. Further commit pulses are ignored (no queuing).
  - On a cycle with latch_mem=1: active_bank toggles at the clock edge; go to COPY with copy counter=0.
  - A latch_mem coincident with the commit cycle (still IDLE) does not swap; the swap waits for the next latch_mem.
- COPY:
  - wr_ready=0, busy=1. Each cycle, shadow[cnt] <= active[cnt] and cnt increments.
  - After cnt=num_pwm-1, return to IDLE. COPY therefore lasts exactly num_pwm cycles.
  - commit_done=1 for exactly one cycle: the final COPY cycle, registered so it is seen as 1 the cycle after cnt=num_pwm-1.
  - latch_mem during COPY: ignored (no swap).
- Display path, combinational, zero latency:
  - pwm_data[i] = bank[disp][i][pwm_addr], where disp = active_bank XOR (state==PENDING & latch_mem).
  - The new frame is therefore shown from the latch_mem cycle itself (pwm_addr=0 plane), giving frame-exact swaps with no mixed frames.
- pwm_addr >= pwm_width (non-power-of-2 widths): pwm_data=0.
- Write with wr_chan >= num_pwm: handshake completes (wr_ready honoured), data discarded, no bank change.
- Reset mid-operation (PENDING or COPY): immediate return to reset state; the pending commit is lost; both banks cleared.
- No other arithmetic. cnt width is $clog2(num_pwm)+1 to avoid wrap on compare.

Test Plan:
- Reset: rst_n low then high -> pwm_data=0 for every pwm_addr 0..15; wr_ready=1; busy=0; commit_done never pulses.
- Basic commit (num_pwm=4, pwm_width=16): write ch0=0x0005, ch2=0x8000, pulse commit -> busy=1, pwm_data stays 0. On the latch_mem cycle: pwm_addr=0 gives 4'b0001, pwm_addr=2 gives 4'b0001, pwm_addr=15 gives 4'b0100. wr_ready low for exactly 4 cycles after the swap; commit_done pulses once.
- Copy coherence: after the previous test, write only ch1=0xFFFF, commit, latch -> pwm_addr=0 gives 4'b0011; pwm_addr=15 gives 4'b0110 (ch0/ch2 preserved).
- Coincident events: commit and latch_mem in the same cycle -> no swap, busy=1; swap occurs only on the next latch_mem. A second commit while PENDING -> exactly one commit_done.
- Out-of-range channel (num_pwm=3): write wr_chan=3, value 0xFFFF, commit, latch -> pwm_data=3'b000 for all addr; handshake completed in 1 cycle.
- Reset in PENDING and in COPY (cnt=2): assert rst_n low -> pwm_data=0 immediately; after release busy=0, wr_ready=1, no commit_done.

Source files
------------

// File: rtl/pwm_frame_ctrl.sv
// pwm_frame_ctrl: double-buffered PWM duty store; swaps banks on the frame boundary
// after a commit, then copies the new active bank back into the shadow bank.
module pwm_frame_ctrl #(
    parameter int pwm_width = 16,
    parameter int num_pwm   = 4,
    localparam int cw = (num_pwm > 1) ? $clog2(num_pwm) : 1,
    localparam int aw = (pwm_width > 1) ? $clog2(pwm_width) : 1,
    localparam int nw = $clog2(num_pwm) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [cw-1:0]        wr_chan,
    input  logic [pwm_width-1:0] wr_value,
    input  logic                 commit,
    output logic                 busy,
    output logic                 commit_done,
    input  logic [aw-1:0]        pwm_addr,
    input  logic                 latch_mem,
    output logic [num_pwm-1:0]   pwm_data
);
    typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;
    state_t state, state_nx;
    logic active_bank, disp, swap, wr_fire, copy_last, addr_ok;
    logic [nw-1:0] cnt;
    logic [pwm_width-1:0] bank [2][num_pwm];
    always_comb begin
        wr_ready  = state == IDLE;
        busy      = state != IDLE;
        swap      = state == PENDING && latch_mem;
        copy_last = state == COPY && cnt == nw'(num_pwm - 1);
        wr_fire   = wr_ready && wr_valid && 32'(wr_chan) < num_pwm;
        addr_ok   = 32'(pwm_addr) < pwm_width;
        disp      = active_bank ^ swap;
        state_nx  = state == IDLE    ? (commit ? PENDING : IDLE) :
                    state == PENDING ? (latch_mem ? COPY : PENDING) :
                    (copy_last ? IDLE : COPY);
    end
    // The bank being swapped in is shown from the latch_mem cycle itself.
    always_comb begin
        pwm_data = '0;
        for (int i = 0; i < num_pwm; i++)
            pwm_data[i] = addr_ok & bank[disp][i][pwm_addr];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            active_bank <= 1'b0;
            cnt         <= '0;
            commit_done <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < num_pwm; i++)
                    bank[b][i] <= '0;
        end else begin
            state       <= state_nx;
            commit_done <= copy_last;
            if (wr_fire)
                bank[~active_bank][wr_chan] <= wr_value;
            if (swap) begin
                active_bank <= ~active_bank;
                cnt         <= '0;
            end
            if (state == COPY) begin
                bank[~active_bank][cnt[cw-1:0]] <= bank[active_bank][cnt[cw-1:0]];
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pwm_frame_ctrl.sv
// tb_pwm_frame_ctrl: vector table, reset corner sequences, a 3-channel instance for
// out-of-range writes, and random traffic against a frame-level reference model.
module tb_pwm_frame_ctrl;
    localparam logic H = 1'b1, L = 1'b0;
    logic clk = 1'b0, rst_n;
    logic wr_valid, wr_ready, commit, busy, commit_done, latch_mem;
    logic [1:0] wr_chan;
    logic [15:0] wr_value;
    logic [3:0] pwm_addr, pwm_data;
    logic w3_valid, w3_ready, w3_commit, w3_busy, w3_done, w3_latch;
    logic [1:0] w3_chan;
    logic [15:0] w3_value;
    logic [3:0] w3_addr;
    logic [2:0] w3_data;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    pwm_frame_ctrl #(.pwm_width(16), .num_pwm(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_chan(wr_chan), .wr_value(wr_value), .commit(commit), .busy(busy),
        .commit_done(commit_done), .pwm_addr(pwm_addr), .latch_mem(latch_mem),
        .pwm_data(pwm_data));

    pwm_frame_ctrl #(.pwm_width(16), .num_pwm(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .wr_valid(w3_valid), .wr_ready(w3_ready),
        .wr_chan(w3_chan), .wr_value(w3_value), .commit(w3_commit), .busy(w3_busy),
        .commit_done(w3_done), .pwm_addr(w3_addr), .latch_mem(w3_latch),
        .pwm_data(w3_data));

    // Reference model: displayed frame, shadow frame, and a phase counter.
    int m_mode, m_left;
    logic m_done;
    logic [15:0] m_disp [4], m_shad [4];

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_done = 1'b0;
        foreach (m_disp[i]) begin m_disp[i] = '0; m_shad[i] = '0; end
    endtask

    task automatic model_step();
        m_done = 1'b0;
        if (m_mode == 0) begin
            if (wr_valid) m_shad[wr_chan] = wr_value;
            if (commit) m_mode = 1;
        end else if (m_mode == 1) begin
            if (latch_mem) begin m_disp = m_shad; m_mode = 2; m_left = 4; end
        end else begin
            m_left--;
            if (m_left == 0) begin m_mode = 0; m_done = 1'b1; end
        end
    endtask

    function automatic logic [3:0] m_data();
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            r[i] = (m_mode == 1 && latch_mem) ? m_shad[i][pwm_addr] : m_disp[i][pwm_addr];
        return r;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string n);
        chk({n, "_data"}, 32'(pwm_data), 32'(m_data()));
        chk({n, "_ready"}, 32'(wr_ready), 32'(m_mode == 0));
        chk({n, "_busy"}, 32'(busy), 32'(m_mode != 0));
        chk({n, "_done"}, 32'(commit_done), 32'(m_done));
    endtask

    task automatic cyc(input logic v, input logic [1:0] ch, input logic [15:0] val,
                       input logic cm, input logic lt, input logic [3:0] a);
        wr_valid = v; wr_chan = ch; wr_value = val; commit = cm; latch_mem = lt; pwm_addr = a;
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic v; logic [1:0] ch; logic [15:0] val; logic cm, lt; logic [3:0] a;
        logic [3:0] d; logic rdy, bsy, dn;
    } vec_t;
    vec_t tbl [29];

    initial begin
        tbl[0]  = '{H, 2'd0, 16'h0005, L, L, 4'd0,  4'b0000, H, L, L};
        tbl[1]  = '{H, 2'd2, 16'h8000, L, L, 4'd15, 4'b0000, H, L, L};
        tbl[2]  = '{L, 2'd0, 16'h0000, H, L, 4'd0,  4'b0000, H, L, L};
        tbl[3]  = '{L, 2'd0, 16'h0000, L, L, 4'd0,  4'b0000, L, H, L};
        tbl[4]  = '{L, 2'd0, 16'h0000, L, H, 4'd0,  4'b0001, L, H, L};
        tbl[5]  = '{L, 2'd0, 16'h0000, L, L, 4'd2,  4'b0001, L, H, L};
        tbl[6]  = '{L, 2'd0, 16'h0000, L, L, 4'd15, 4'b0100, L, H, L};
        tbl[7]  = '{L, 2'd0, 16'h0000, L, L, 4'd1,  4'b0000, L, H, L};
        tbl[8]  = '{L, 2'd0, 16'h0000, L, L, 4'd0,  4'b0001, L, H, L};
        tbl[9]  = '{L, 2'd0, 16'h0000, L, L, 4'd0,  4'b0001, H, L, H};
        tbl[10] = '{L, 2'd0, 16'h0000, L, L, 4'd0,  4'b0001, H, L, L};
        tbl[11] = '{H, 2'd1, 16'hFFFF, L, L, 4'd15, 4'b0100, H, L, L};
        tbl[12] = '{L, 2'd0, 16'h0000, H, L, 4'd0,  4'b0001, H, L, L};
        tbl[13] = '{L, 2'd0, 16'h0000, L, H, 4'd0,  4'b0011, L, H, L};
        tbl[14] = '{L, 2'd0, 16'h0000, L, L, 4'd15, 4'b0110, L, H, L};
        tbl[15] = '{L, 2'd0, 16'h0000, L, L, 4'd0,  4'b0011, L, H, L};
        tbl[16] = '{L, 2'd0, 16'h0000, L, L, 4'd0,  4'b0011, L, H, L};
        tbl[17] = '{L, 2'd0, 16'h0000, L, L, 4'd0,  4'b0011, L, H, L};
        tbl[18] = '{L, 2'd0, 16'h0000, L, L, 4'd15, 4'b0110, H, L, H};
        tbl[19] = '{H, 2'd3, 16'h0001, H, H, 4'd0,  4'b0011, H, L, L};
        tbl[20] = '{L, 2'd0, 16'h0000, L, L, 4'd0,  4'b0011, L, H, L};
        tbl[21] = '{L, 2'd0, 16'h0000, H, L, 4'd0,  4'b0011, L, H, L};
        tbl[22] = '{L, 2'd0, 16'h0000, L, H, 4'd0,  4'b1011, L, H, L};
        tbl[23] = '{L, 2'd0, 16'h0000, L, L, 4'd0,  4'b1011, L, H, L};
        tbl[24] = '{L, 2'd0, 16'h0000, L, L, 4'd0,  4'b1011, L, H, L};
        tbl[25] = '{L, 2'd0, 16'h0000, L, L, 4'd0,  4'b1011, L, H, L};
        tbl[26] = '{L, 2'd0, 16'h0000, L, L, 4'd0,  4'b1011, L, H, L};
        tbl[27] = '{L, 2'd0, 16'h0000, L, L, 4'd0,  4'b1011, H, L, H};
        tbl[28] = '{L, 2'd0, 16'h0000, L, L, 4'd0,  4'b1011, H, L, L};

        rst_n = 1'b0;
        wr_valid = 0; wr_chan = 0; wr_value = 0; commit = 0; latch_mem = 0; pwm_addr = 0;
        w3_valid = 0; w3_chan = 0; w3_value = 0; w3_commit = 0; w3_latch = 0; w3_addr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int a = 0; a < 16; a++) begin
            cyc(L, 2'd0, 16'h0, L, L, 4'(a));
            chk("reset_data", 32'(pwm_data), 0);
            chk("reset_ready", 32'(wr_ready), 1);
            chk("reset_busy", 32'(busy), 0);
            chk("reset_done", 32'(commit_done), 0);
            tick();
        end

        for (int r = 0; r < 29; r++) begin
            cyc(tbl[r].v, tbl[r].ch, tbl[r].val, tbl[r].cm, tbl[r].lt, tbl[r].a);
            chk($sformatf("vec%0d_data", r), 32'(pwm_data), 32'(tbl[r].d));
            chk($sformatf("vec%0d_ready", r), 32'(wr_ready), 32'(tbl[r].rdy));
            chk($sformatf("vec%0d_busy", r), 32'(busy), 32'(tbl[r].bsy));
            chk($sformatf("vec%0d_done", r), 32'(commit_done), 32'(tbl[r].dn));
            tick();
        end

        // Reset while PENDING.
        cyc(L, 2'd0, 16'h0, H, L, 4'd0); tick();
        cyc(L, 2'd0, 16'h0, L, L, 4'd0);
        chk_model("pend_pre");
        rst_n = 1'b0; #1;
        chk("pend_rst_data", 32'(pwm_data), 0);
        chk("pend_rst_busy", 32'(busy), 0);
        @(posedge clk); #1 rst_n = 1'b1; model_reset();
        for (int k = 0; k < 4; k++) begin cyc(L, 2'd0, 16'h0, L, L, 4'(k)); chk_model("pend_post"); tick(); end

        // Reset while COPY with cnt=2.
        cyc(H, 2'd1, 16'hFFFF, H, L, 4'd0); tick();
        cyc(L, 2'd0, 16'h0, L, H, 4'd0); chk_model("copy_latch"); tick();
        cyc(L, 2'd0, 16'h0, L, L, 4'd0); tick(); tick();
        chk_model("copy_pre");
        chk("copy_pre_data", 32'(pwm_data), 32'(4'b0010));
        rst_n = 1'b0; #1;
        chk("copy_rst_data", 32'(pwm_data), 0);
        chk("copy_rst_busy", 32'(busy), 0);
        chk("copy_rst_ready", 32'(wr_ready), 1);
        @(posedge clk); #1 rst_n = 1'b1; model_reset();
        for (int k = 0; k < 6; k++) begin cyc(L, 2'd0, 16'h0, L, L, 4'(k)); chk_model("copy_post"); tick(); end

        // Three-channel instance: write to channel 3 is accepted but dropped.
        w3_valid = 1; w3_chan = 2'd3; w3_value = 16'hFFFF; #4;
        chk("oor_ready", 32'(w3_ready), 1); tick();
        w3_valid = 0; w3_commit = 1; #4;
        chk("oor_ready_after", 32'(w3_ready), 1); tick();
        w3_commit = 0; w3_latch = 1; #4;
        chk("oor_busy", 32'(w3_busy), 1);
        chk("oor_latch_data", 32'(w3_data), 0); tick();
        w3_latch = 0;
        for (int a = 0; a < 16; a++) begin
            w3_addr = 4'(a); #4;
            chk($sformatf("oor_data_a%0d", a), 32'(w3_data), 0); tick();
        end
        w3_valid = 1; w3_chan = 2'd2; w3_value = 16'h0020; tick();
        w3_valid = 0; w3_commit = 1; tick();
        w3_commit = 0; w3_latch = 1; w3_addr = 4'd5; #4;
        chk("ch2_data", 32'(w3_data), 32'(3'b100)); tick();
        w3_latch = 0; repeat (6) tick();

        for (int k = 0; k < 600; k++) begin
            cyc(1'($urandom_range(1)), 2'($urandom_range(3)), 16'($urandom),
                $urandom_range(5) == 0, $urandom_range(4) == 0, 4'($urandom_range(15)));
            chk_model("rand");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
